// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for an approximate WxW unsigned multiplier: recomputes x*y and
// accumulates error count, saturating sum and max of |error|. Optional macro: ERR_BIAS_EN.
module approx_mult_err_monitor #(
    parameter int unsigned W      = 8,
    parameter int unsigned N_LOG2 = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        y,
    input  logic [2*W-1:0]      z_approx,
    output logic                busy,
    output logic                done,
    output logic [N_LOG2:0]     err_count,
    output logic [ACC_W-1:0]    sum_ed,
    output logic [2*W-1:0]      max_ed,
    output logic [ACC_W-1:0]    sum_sed
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = N_LOG2 + 1;
    localparam logic [CW-1:0] RUN_LEN  = {1'b1, {N_LOG2{1'b0}}};
    localparam logic [CW-1:0] LAST_IDX = RUN_LEN - CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  sample_cnt_q, sample_cnt_d;
    logic           drain_cnt_q, drain_cnt_d;

    logic           s1_valid_q;
    logic [PW-1:0]  s1_p_q, s1_z_q;
    logic           s2_valid_q;
    logic [PW-1:0]  s2_d_q;

    logic [CW-1:0]    err_count_q, err_count_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [PW-1:0]    max_ed_q, max_ed_d;
    logic [ACC_W:0]   sum_ext;

    logic accept;
    logic start_ok;

    assign in_ready = (state_q == StRun) && (sample_cnt_q != RUN_LEN);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign done     = (state_q == StDone);

    // FSM next state and sample counter
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    state_d      = StRun;
                    sample_cnt_d = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + CW'(1);
                    if (sample_cnt_q == LAST_IDX) begin
                        state_d     = StDrain;
                        drain_cnt_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            drain_cnt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    // Stage 1: exact product and captured approximation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_z_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_p_q <= PW'(x) * PW'(y);
                s1_z_q <= z_approx;
            end
        end
    end

    // Stage 2: absolute error distance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_d_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_d_q <= (s1_p_q >= s1_z_q) ? (s1_p_q - s1_z_q) : (s1_z_q - s1_p_q);
            end
        end
    end

    assign sum_ext = {1'b0, sum_ed_q} + (ACC_W + 1)'(s2_d_q);

    always_comb begin
        err_count_d = err_count_q;
        sum_ed_d    = sum_ed_q;
        max_ed_d    = max_ed_q;
        if (start_ok) begin
            err_count_d = '0;
            sum_ed_d    = '0;
            max_ed_d    = '0;
        end else if (s2_valid_q) begin
            if (s2_d_q != '0) begin
                err_count_d = err_count_q + CW'(1);
            end
            if (s2_d_q > max_ed_q) begin
                max_ed_d = s2_d_q;
            end
            // Clamp at all-ones instead of wrapping
            sum_ed_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
        end else begin
            err_count_q <= err_count_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
        end
    end

    assign err_count = err_count_q;
    assign sum_ed    = sum_ed_q;
    assign max_ed    = max_ed_q;

`ifdef ERR_BIAS_EN
    logic [PW:0]      s2_sed_q;
    logic [ACC_W-1:0] sum_sed_q, sum_sed_d;
    logic [ACC_W-1:0] sed_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sed_q <= '0;
        end else if (s1_valid_q) begin
            s2_sed_q <= {1'b0, s1_z_q} - {1'b0, s1_p_q};
        end
    end

    assign sed_ext = ACC_W'($signed(s2_sed_q));

    // Signed bias sum wraps on overflow by design
    always_comb begin
        sum_sed_d = sum_sed_q;
        if (start_ok) begin
            sum_sed_d = '0;
        end else if (s2_valid_q) begin
            sum_sed_d = sum_sed_q + sed_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_sed_q <= '0;
        end else begin
            sum_sed_q <= sum_sed_d;
        end
    end

    assign sum_sed = sum_sed_q;
`else
    assign sum_sed = '0;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Scoreboard bench for approx_mult_err_monitor (W=8, N_LOG2=2, ACC_W=17); directed runs with
// hand-computed statistics, checked by a monitor when done rises.
module tb_approx_mult_err_monitor;

    localparam int unsigned W      = 8;
    localparam int unsigned N_LOG2 = 2;
    localparam int unsigned ACC_W  = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      x = '0;
    logic [W-1:0]      y = '0;
    logic [2*W-1:0]    z_approx = '0;
    logic              busy;
    logic              done;
    logic [N_LOG2:0]   err_count;
    logic [ACC_W-1:0]  sum_ed;
    logic [2*W-1:0]    max_ed;
    logic [ACC_W-1:0]  sum_sed;

    approx_mult_err_monitor #(
        .W      (W),
        .N_LOG2 (N_LOG2),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z_approx  (z_approx),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .sum_sed   (sum_sed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] err;
        logic [31:0] sum;
        logic [31:0] mx;
        logic [31:0] sed;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_xfer = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sed_exp(input logic [31:0] v);
`ifdef ERR_BIAS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Monitor: on each rising done, pop the expected statistics of that run
    always @(negedge clk) begin
        done_prev <= done;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("err_count", 32'(err_count), e.err);
                check("sum_ed", 32'(sum_ed), e.sum);
                check("max_ed", 32'(max_ed), e.mx);
                check("sum_sed", 32'(sum_sed), e.sed);
                // done high in the third cycle after the final transfer = 2 edges later
                check("done_latency", 32'(cyc - last_xfer), 32'd2);
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_sum_ed"}, 32'(sum_ed), 32'd0);
        check({tag, "_max_ed"}, 32'(max_ed), 32'd0);
        check({tag, "_sum_sed"}, 32'(sum_sed), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Called just after a negedge; returns on the negedge following the accepting edge
    task automatic send(input logic [39:0] v, input bit bubble);
        int t = 0;
        {x, y, z_approx} = v;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            @(negedge clk);
            last_xfer = cyc;
        end
        in_valid = 1'b0;
        if (bubble) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd0);
    endtask

    task automatic run4(input string tag, input logic [39:0] v0, input logic [39:0] v1,
                        input logic [39:0] v2, input logic [39:0] v3, input bit bubble,
                        input exp_t e);
        sb_q.push_back(e);
        pulse_start();
        send(v0, bubble);
        send(v1, bubble);
        send(v2, bubble);
        send(v3, bubble);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_drain_busy"}, 32'(busy), 32'd1);
        wait_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        // T1 reset
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");

        // T3 single error
        e = '{err: 1, sum: 1, mx: 1, sed: sed_exp(32'h1FFFF)};
        run4("t3", {8'd3, 8'd5, 16'd15}, {8'd3, 8'd5, 16'd14},
             {8'd255, 8'd255, 16'd65025}, {8'd0, 8'd0, 16'd0}, 1'b0, e);

        // T4 same samples with bubbles
        run4("t4", {8'd3, 8'd5, 16'd15}, {8'd3, 8'd5, 16'd14},
             {8'd255, 8'd255, 16'd65025}, {8'd0, 8'd0, 16'd0}, 1'b1, e);

        // T5 saturation: 4*65025 clamps to 2^17-1; signed sum -260100 wraps to 2044
        e = '{err: 4, sum: 131071, mx: 65025, sed: sed_exp(32'd2044)};
        run4("t5", {8'd255, 8'd255, 16'd0}, {8'd255, 8'd255, 16'd0},
             {8'd255, 8'd255, 16'd0}, {8'd255, 8'd255, 16'd0}, 1'b0, e);

        // Mixed over/under estimates: d = 10,0,6,45; signed = +10,0,-6,+45
        e = '{err: 3, sum: 61, mx: 45, sed: sed_exp(32'd49)};
        run4("mix", {8'd10, 8'd10, 16'd110}, {8'd200, 8'd100, 16'd20000},
             {8'd16, 8'd16, 16'd250}, {8'd255, 8'd1, 16'd300}, 1'b0, e);

        // start pulse in RUN must be ignored: d = 0,1,1,0; signed = 0,+1,-1,0
        e = '{err: 2, sum: 2, mx: 1, sed: sed_exp(32'd0)};
        sb_q.push_back(e);
        pulse_start();
        send({8'd12, 8'd12, 16'd144}, 1'b0);
        send({8'd5, 8'd5, 16'd26}, 1'b0);
        pulse_start();
        check("ign_start_busy", 32'(busy), 32'd1);
        send({8'd9, 8'd9, 16'd80}, 1'b0);
        send({8'd4, 8'd4, 16'd16}, 1'b0);
        wait_done("ign");

        // T6 reset mid-run: first sample visible two edges after acceptance
        pulse_start();
        send({8'd255, 8'd255, 16'd0}, 1'b0);
        send({8'd255, 8'd255, 16'd0}, 1'b0);
        @(negedge clk);
        check("mid_err_count", 32'(err_count), 32'd1);
        check("mid_max_ed", 32'(max_ed), 32'd65025);
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_zero("after_mid_reset");

        // Fresh run after abort: only 7*9 vs 60 differs (d=3, signed -3)
        e = '{err: 1, sum: 3, mx: 3, sed: sed_exp(32'h1FFFD)};
        run4("t6", {8'd1, 8'd1, 16'd1}, {8'd2, 8'd2, 16'd4},
             {8'd7, 8'd9, 16'd60}, {8'd100, 8'd3, 16'd300}, 1'b0, e);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
